piso_serializer8: RTL and testbench
===================================

// Module: piso_serializer8
// PURPOSE
//   Parallel-in/serial-out stage. Accepts one 8-bit word over a valid/ready handshake and
//   emits it one bit per beat over a second valid/ready handshake.
//   A 3-bit select counter drives an 8:1 mux tree that picks the current bit.
//   Sits between a byte-wide producer and any bit-serial consumer (shift link, UART-style TX).
// PARAMETERS
//   MSB_FIRST      0   0: bit0 first (sel = cnt); 1: bit7 first (sel = ~cnt)
//   BACK_TO_BACK   1   1: new word may load on the same cycle the last bit transfers; 0: one idle cycle between words
// PORTS
//   clk         in   1  single clock, all logic rising-edge
//   rst         in   1  synchronous, active-high reset
//   load_valid  in   1  upstream word available
//   load_data   in   8  word to serialize, sampled on load handshake
//   load_ready  out  1  block can accept a word this cycle
//   ser_valid   out  1  ser_out carries a valid bit
//   ser_out     out  1  current serial bit
//   ser_last    out  1  high with the 8th bit of a word
//   ser_ready   in   1  downstream accepts the bit this cycle
// BEHAVIOUR
//   State and reset
//   - States: IDLE, SHIFT. Registers: state, cnt[2:0], data_q[7:0].
//   - rst high at clk edge: state=IDLE, cnt=0, data_q=0.
//   - While rst is high: load_ready=0, ser_valid=0, ser_out=0, ser_last=0 (all gated combinationally).
//   Handshake rules
//   - load_ready = !rst & (IDLE | (BACK_TO_BACK & SHIFT & cnt==7 & ser_ready)).
//   - Load fires on load_valid & load_ready: data_q<=load_data, cnt<=0, state<=SHIFT.
//   - Latency: first bit valid the cycle after the load handshake.
//   - Outputs in SHIFT: ser_valid=1, ser_out=data_q[sel], ser_last=(cnt==7).
//   - Outputs in IDLE: ser_valid=0, ser_out=0, ser_last=0.
//   - A beat transfers on ser_valid & ser_ready. Transfer with cnt<7: cnt<=cnt+1.
//   - Transfer with cnt==7: if a load fires the same cycle, stay in SHIFT with cnt=0 and the new data_q.
//     Otherwise go to IDLE with cnt=0.
//   - ser_ready=0 in SHIFT: data_q, cnt, ser_out and ser_last all hold. No timeout.
//   - ser_valid never drops mid-word except on rst.
//   Boundary conditions
//   - load_valid in SHIFT with cnt<7, or with no transfer: ignored, since load_ready=0.
//   - cnt never wraps on its own; it returns to 0 only via load or last transfer.
//   - rst mid-word aborts the word. Remaining bits are dropped and the next word starts at its first bit.
//   - ser_ready is a don't-care in IDLE. load_data is a don't-care when no handshake occurs.
// STRUCTURE
//   Shared package / header:
//   - WORD_W=8, CNT_W=3
//   - state encoding IDLE=1'b0, SHIFT=1'b1
//   Sub-module: the existing 8:1 mux tree mux8_1_2_1 (.sel(sel), .in(data_q), .out(mux_bit)).
//   - ser_out = ser_valid & mux_bit.
//   Top level holds the FSM, counter, data register and handshake logic.
// TESTING
//   1. Reset: rst=1 for 2 cycles with load_valid=1, load_data=8'hFF -> load_ready=0, ser_valid=0, no capture;
//      after rst falls, load_ready=1.
//   2. MSB_FIRST=0, ser_ready=1, load 8'hC1 -> from the next cycle ser_out = 1,0,0,0,0,0,1,1;
//      ser_last on the 8th beat only; then IDLE.
//   3. MSB_FIRST=1, load 8'hC1 -> ser_out = 1,1,0,0,0,0,0,1; ser_last on the 8th beat.
//   4. Backpressure: load 8'hA5, drop ser_ready for 3 cycles at beat 3 -> ser_out and ser_last held;
//      all 8 bits correct; word completes in 11 cycles.
//   5. Back-to-back (BACK_TO_BACK=1): load_valid held with 8'h0F then 8'hF0 -> 16 contiguous valid beats;
//      load_ready high only on beat 8 of the first word.
//      With BACK_TO_BACK=0 -> exactly one idle cycle between the two words.
//   6. rst pulse during beat 4 of 8'h3C -> ser_valid=0 while rst is high;
//      next load 8'h81 starts from its first bit, no residue.

Source files
------------

// File: rtl/piso_serializer8_pkg.sv
// Shared definitions for the byte-to-bit serializer: word and counter widths,
// the two-state FSM encoding, and the helper that maps the beat counter to a
// bit position depending on the serialization order.
package piso_serializer8_pkg;

   localparam int WORD_W = 8;
   localparam int CNT_W  = 3;

   // Counter value that marks the final bit of a word.
   localparam logic [CNT_W-1:0] CNT_LAST = 3'd7;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Beat counter to bit index: LSB-first uses the count directly, MSB-first
   // walks the word from the top by inverting it.
   function automatic logic [CNT_W-1:0] bit_select(input logic [CNT_W-1:0] cnt,
                                                   input bit               msb_first);
      bit_select = msb_first ? ~cnt : cnt;
   endfunction

endpackage

// File: rtl/piso_serializer8_mux8_1_2_1.sv
// 8:1 bit multiplexer built as a three-level tree of 2:1 selects.
// sel[0] picks within adjacent pairs, sel[1] within pairs of pairs and
// sel[2] between the two halves, so out == in[sel].
module mux8_1_2_1 (
   input  logic [2:0] sel,
   input  logic [7:0] in,
   output logic       out
);

   logic [3:0] level1;
   logic [1:0] level2;

   // First level: choose odd or even bit of each adjacent pair.
   genvar i;
   generate
      for (i = 0; i < 4; i++) begin : gen_level1
         assign level1[i] = sel[0] ? in[2*i+1] : in[2*i];
      end
      for (i = 0; i < 2; i++) begin : gen_level2
         assign level2[i] = sel[1] ? level1[2*i+1] : level1[2*i];
      end
   endgenerate

   // Final level: choose the upper or lower nibble result.
   assign out = sel[2] ? level2[1] : level2[0];

endmodule

// File: rtl/piso_serializer8.sv
// Parallel-in / serial-out stage. A byte is accepted over the load handshake
// and then presented one bit per beat on the serial handshake, LSB or MSB
// first. With BACK_TO_BACK set, the next byte may be accepted on the very
// cycle the last bit of the current one is taken, giving a gap-free stream.
module piso_serializer8
   import piso_serializer8_pkg::*;
#(
   parameter bit MSB_FIRST    = 1'b0,
   parameter bit BACK_TO_BACK = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   input  logic [WORD_W-1:0] load_data,
   output logic              load_ready,
   output logic              ser_valid,
   output logic              ser_out,
   output logic              ser_last,
   input  logic              ser_ready
);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [WORD_W-1:0] data_q;

   logic              in_shift;
   logic              at_last;
   logic              load_fire;
   logic              beat_fire;
   logic [CNT_W-1:0]  sel;
   logic              mux_bit;

   assign in_shift = (state == SHIFT);
   assign at_last  = (cnt == CNT_LAST);

   // Accept a word whenever idle, or, in back-to-back mode, exactly when the
   // final bit of the current word is being taken downstream. Reset blocks
   // both handshakes combinationally so nothing leaks out while it is held.
   assign load_ready = !rst && (!in_shift || (BACK_TO_BACK && at_last && ser_ready));
   assign load_fire  = load_valid && load_ready;

   assign ser_valid  = !rst && in_shift;
   assign ser_last   = ser_valid && at_last;
   assign beat_fire  = ser_valid && ser_ready;

   assign sel     = bit_select(cnt, MSB_FIRST);
   assign ser_out = ser_valid & mux_bit;

   mux8_1_2_1 u_mux (
      .sel (sel),
      .in  (data_q),
      .out (mux_bit)
   );

   // FSM, beat counter and data register. A load has priority over the beat
   // bookkeeping because in back-to-back mode the two coincide on the last
   // bit, and the new word must then restart from its first bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         data_q <= '0;
      end else if (load_fire) begin
         state  <= SHIFT;
         cnt    <= '0;
         data_q <= load_data;
      end else if (beat_fire) begin
         if (at_last) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_piso_serializer8.sv
// Self-checking bench for piso_serializer8. Three instances run side by side:
// LSB-first back-to-back, MSB-first back-to-back, and LSB-first with an idle
// cycle between words. A per-instance scoreboard queues the expected bits on
// each load handshake and pops them on each serial beat; directed checks
// cover reset, ordering, backpressure, word spacing and mid-word reset.
module tb_piso_serializer8;

   localparam int N = 3;
   localparam bit [N-1:0] MSB_CFG = 3'b010;
   localparam bit [N-1:0] B2B_CFG = 3'b011;

   logic       clk;
   logic       rst;
   logic       load_valid [N];
   logic [7:0] load_data  [N];
   logic       ser_ready  [N];
   logic       load_ready [N];
   logic       ser_valid  [N];
   logic       ser_out    [N];
   logic       ser_last   [N];

   int check_count = 0;
   int pass_count  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input int got, input int expected);
      check_count++;
      if (got == expected) pass_count++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, expected);
   endtask

   // Expected bit for beat b of word d in the given order.
   function automatic logic expBit(input logic [7:0] d, input int b, input bit msb);
      expBit = msb ? d[7-b] : d[b];
   endfunction

   // Drive the same handshake inputs to every instance.
   task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic ready);
      for (int g = 0; g < N; g++) begin
         load_valid[g] = valid;
         load_data[g]  = data;
         ser_ready[g]  = ready;
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   genvar g;
   generate
      for (g = 0; g < N; g++) begin : gen_dut
         piso_serializer8 #(
            .MSB_FIRST    (MSB_CFG[g]),
            .BACK_TO_BACK (B2B_CFG[g])
         ) dut (
            .clk        (clk),
            .rst        (rst),
            .load_valid (load_valid[g]),
            .load_data  (load_data[g]),
            .load_ready (load_ready[g]),
            .ser_valid  (ser_valid[g]),
            .ser_out    (ser_out[g]),
            .ser_last   (ser_last[g]),
            .ser_ready  (ser_ready[g])
         );

         logic [1:0] exp_q [$];

         // Scoreboard: pop on each transferred beat, push a full word on each
         // accepted load; reset drops whatever was still pending.
         always @(negedge clk) begin
            logic [1:0] e;
            if (rst) begin
               exp_q.delete();
            end else begin
               if (ser_valid[g] && ser_ready[g]) begin
                  if (exp_q.size() == 0) begin
                     checkOutput($sformatf("sb_unexpected_beat_dut%0d", g), 1, 0);
                  end else begin
                     e = exp_q.pop_front();
                     checkOutput($sformatf("sb_bit_dut%0d", g), int'(ser_out[g]), int'(e[0]));
                     checkOutput($sformatf("sb_last_dut%0d", g), int'(ser_last[g]), int'(e[1]));
                  end
               end
               if (load_valid[g] && load_ready[g]) begin
                  for (int b = 0; b < 8; b++)
                     exp_q.push_back({(b == 7), expBit(load_data[g], b, MSB_CFG[g])});
               end
            end
         end
      end
   endgenerate

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   logic [7:0] seq_lsb;
   logic [7:0] seq_msb;
   int valid_cycles [N];
   int beat_no      [N];
   int first_t      [N];
   int last_t       [N];
   int stage        [N];

   initial begin
      seq_lsb = 8'b1100_0001;
      seq_msb = 8'b1000_0011;

      // Reset held for two cycles while a word is offered.
      rst = 1'b1;
      applyStimulus(1'b1, 8'hFF, 1'b0);
      repeat (2) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            checkOutput($sformatf("rst_load_ready_dut%0d", i), int'(load_ready[i]), 0);
            checkOutput($sformatf("rst_ser_valid_dut%0d", i), int'(ser_valid[i]), 0);
            checkOutput($sformatf("rst_ser_out_dut%0d", i), int'(ser_out[i]), 0);
         end
         nextCycle();
      end
      rst = 1'b0;
      applyStimulus(1'b0, 8'h00, 1'b1);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         checkOutput($sformatf("post_rst_load_ready_dut%0d", i), int'(load_ready[i]), 1);
         checkOutput($sformatf("post_rst_no_capture_dut%0d", i), int'(ser_valid[i]), 0);
      end
      nextCycle();

      // Bit ordering for 8'hC1 in both orders.
      applyStimulus(1'b1, 8'hC1, 1'b1);
      @(negedge clk);
      for (int i = 0; i < N; i++)
         checkOutput($sformatf("idle_load_ready_dut%0d", i), int'(load_ready[i]), 1);
      nextCycle();
      applyStimulus(1'b0, 8'h00, 1'b1);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            checkOutput($sformatf("c1_valid_dut%0d_b%0d", i, k), int'(ser_valid[i]), 1);
            checkOutput($sformatf("c1_bit_dut%0d_b%0d", i, k), int'(ser_out[i]),
                        MSB_CFG[i] ? int'(seq_msb[k]) : int'(seq_lsb[k]));
            checkOutput($sformatf("c1_last_dut%0d_b%0d", i, k), int'(ser_last[i]), (k == 7) ? 1 : 0);
         end
         nextCycle();
      end
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         checkOutput($sformatf("c1_idle_valid_dut%0d", i), int'(ser_valid[i]), 0);
         checkOutput($sformatf("c1_idle_ready_dut%0d", i), int'(load_ready[i]), 1);
      end
      nextCycle();

      // Backpressure: ser_ready low for three cycles at beat 3 of 8'hA5.
      applyStimulus(1'b1, 8'hA5, 1'b1);
      @(negedge clk);
      nextCycle();
      applyStimulus(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < N; i++) valid_cycles[i] = 0;
      for (int c = 0; c < 20; c++) begin
         for (int i = 0; i < N; i++) ser_ready[i] = !(c >= 3 && c < 6);
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (ser_valid[i]) valid_cycles[i]++;
            if (c >= 3 && c < 6) begin
               checkOutput($sformatf("bp_hold_valid_dut%0d_c%0d", i, c), int'(ser_valid[i]), 1);
               checkOutput($sformatf("bp_hold_bit_dut%0d_c%0d", i, c), int'(ser_out[i]),
                           int'(expBit(8'hA5, 3, MSB_CFG[i])));
               checkOutput($sformatf("bp_hold_last_dut%0d_c%0d", i, c), int'(ser_last[i]), 0);
            end
            if (c == 10)
               checkOutput($sformatf("bp_last_dut%0d", i), int'(ser_last[i]), 1);
         end
         nextCycle();
      end
      for (int i = 0; i < N; i++)
         checkOutput($sformatf("bp_word_cycles_dut%0d", i), valid_cycles[i], 11);

      // Two words offered continuously: 8'h0F then 8'hF0.
      applyStimulus(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < N; i++) begin
         beat_no[i] = 0;
         first_t[i] = -1;
         last_t[i]  = -1;
         stage[i]   = 0;
      end
      for (int t = 0; t < 30; t++) begin
         for (int i = 0; i < N; i++) begin
            load_valid[i] = (stage[i] < 2);
            load_data[i]  = (stage[i] == 0) ? 8'h0F : 8'hF0;
         end
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (ser_valid[i]) begin
               beat_no[i]++;
               if (first_t[i] < 0) first_t[i] = t;
               last_t[i] = t;
               if (beat_no[i] <= 15)
                  checkOutput($sformatf("b2b_load_ready_dut%0d_beat%0d", i, beat_no[i]), int'(load_ready[i]),
                              (B2B_CFG[i] && beat_no[i] == 8) ? 1 : 0);
            end else if (!B2B_CFG[i] && beat_no[i] == 8) begin
               checkOutput($sformatf("gap_load_ready_dut%0d", i), int'(load_ready[i]), 1);
            end
            if (load_valid[i] && load_ready[i]) stage[i]++;
         end
         nextCycle();
      end
      applyStimulus(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < N; i++) begin
         checkOutput($sformatf("b2b_beats_dut%0d", i), beat_no[i], 16);
         checkOutput($sformatf("b2b_span_dut%0d", i), last_t[i] - first_t[i] + 1, B2B_CFG[i] ? 16 : 17);
         checkOutput($sformatf("b2b_words_dut%0d", i), stage[i], 2);
      end

      // Reset pulse during beat 4 of 8'h3C, then a clean 8'h81.
      nextCycle();
      applyStimulus(1'b1, 8'h3C, 1'b1);
      @(negedge clk);
      nextCycle();
      applyStimulus(1'b0, 8'h00, 1'b1);
      repeat (3) begin
         @(negedge clk);
         nextCycle();
      end
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         checkOutput($sformatf("midrst_valid_dut%0d", i), int'(ser_valid[i]), 0);
         checkOutput($sformatf("midrst_load_ready_dut%0d", i), int'(load_ready[i]), 0);
         checkOutput($sformatf("midrst_last_dut%0d", i), int'(ser_last[i]), 0);
      end
      nextCycle();
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         checkOutput($sformatf("after_rst_valid_dut%0d", i), int'(ser_valid[i]), 0);
         checkOutput($sformatf("after_rst_ready_dut%0d", i), int'(load_ready[i]), 1);
      end
      nextCycle();
      applyStimulus(1'b1, 8'h81, 1'b1);
      @(negedge clk);
      nextCycle();
      applyStimulus(1'b0, 8'h00, 1'b1);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            checkOutput($sformatf("w81_valid_dut%0d_b%0d", i, k), int'(ser_valid[i]), 1);
            checkOutput($sformatf("w81_bit_dut%0d_b%0d", i, k), int'(ser_out[i]),
                        int'(expBit(8'h81, k, MSB_CFG[i])));
            checkOutput($sformatf("w81_last_dut%0d_b%0d", i, k), int'(ser_last[i]), (k == 7) ? 1 : 0);
         end
         nextCycle();
      end
      @(negedge clk);
      for (int i = 0; i < N; i++)
         checkOutput($sformatf("w81_idle_dut%0d", i), int'(ser_valid[i]), 0);

      // Every queued bit must have been delivered.
      checkOutput("sb_drained_dut0", gen_dut[0].exp_q.size(), 0);
      checkOutput("sb_drained_dut1", gen_dut[1].exp_q.size(), 0);
      checkOutput("sb_drained_dut2", gen_dut[2].exp_q.size(), 0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
